multi_adder_pipe: RTL and testbench

MULTI_ADDER_PIPE -- requirements
Module: multi_adder_pipe

---
 rtl/multi_adder_pipe.sv | 95 +++++++++
 tb/tb_multi_adder_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_adder_pipe.sv
// multi_adder_pipe: two-stage pipelined adder of N unsigned W-bit operands.
// Stage 1 registers the operands. Stage 2 registers the sum with overflow
// and an optional saturation. The design uses valid/ready handshakes on
// both sides and keeps a saturating count of delivered overflow results.
module multi_adder_pipe #(
    parameter int W   = 6,
    parameter int N   = 3,
    parameter int SAT = 0,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   sum_s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           ovf,
    output logic [CW-1:0]  ovf_cnt
);

    // The sum of N values of 2^W-1 always fits in this many bits.
    localparam int FW = W + $clog2(N);

    logic           s1_valid;
    logic [N*W-1:0] s1_data;
    logic           s2_load;
    logic           out_xfer;
    logic [FW-1:0]  sum_full;
    logic           sum_ovf;
    logic [W-1:0]   sum_next;

    // Stage 2 advances when it holds a result that is being taken, or when it is empty.
    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = (!s1_valid || s2_load) && !rst;
    assign out_xfer = out_valid && out_ready;

    // Full-width sum of the registered operands.
    always_comb begin
        // NOTE: sum_full gets a default before the loop, so no latch is inferred.
        sum_full = '0;
        for (int k = 0; k < N; k++) begin
            sum_full = sum_full + FW'(s1_data[k*W +: W]);
        end
    end

    // Overflow detection and result selection (wrap or saturate).
    always_comb begin
        sum_ovf  = |sum_full[FW-1:W];
        sum_next = sum_full[W-1:0];
        if (SAT != 0 && sum_ovf) begin
            sum_next = {W{1'b1}};
        end
    end

    // Stage 1: capture the operands on an input transfer. Clear when stage 2 drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all registered state, so every flop sees pre-edge values.
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: register the result. Hold while stalled. Drop valid once it is delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_s     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (s2_load) begin
            sum_s     <= sum_next;
            ovf       <= sum_ovf;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Count delivered overflow results. The count stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (out_xfer && ovf && (ovf_cnt != {CW{1'b1}})) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_adder_pipe.sv
// Directed testbench for multi_adder_pipe. Three instances share one stimulus:
// wrap mode with an 8-bit counter, saturate mode with an 8-bit counter,
// and wrap mode with a 2-bit counter. All three use W=6 and N=4.
module tb_multi_adder_pipe;

    logic        clk;
    logic        rst;
    logic [23:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic       in_ready_w, in_ready_s, in_ready_c;
    logic       out_valid_w, out_valid_s, out_valid_c;
    logic [5:0] sum_w, sum_sat, sum_c;
    logic       ovf_w, ovf_sat, ovf_c;
    logic [7:0] cnt_w, cnt_sat;
    logic [1:0] cnt_c;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt8 = 0;
    int exp_cnt2 = 0;

    multi_adder_pipe #(.W(6), .N(4), .SAT(0), .CW(8)) u_wrap (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_w), .sum_s(sum_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .ovf(ovf_w), .ovf_cnt(cnt_w)
    );

    multi_adder_pipe #(.W(6), .N(4), .SAT(1), .CW(8)) u_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_s), .sum_s(sum_sat), .out_valid(out_valid_s),
        .out_ready(out_ready), .ovf(ovf_sat), .ovf_cnt(cnt_sat)
    );

    multi_adder_pipe #(.W(6), .N(4), .SAT(0), .CW(2)) u_cnt (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_c), .sum_s(sum_c), .out_valid(out_valid_c),
        .out_ready(out_ready), .ovf(ovf_c), .ovf_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit, so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [23:0] pack(input logic [5:0] a, input logic [5:0] b,
                                         input logic [5:0] c, input logic [5:0] d);
        return {d, c, b, a};
    endfunction

    // Track the counter values that should result from a delivered result.
    task automatic note_delivery(input int exp_ovf);
        if (exp_ovf != 0) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3)   exp_cnt2++;
        end
    endtask

    // Send one vector from idle with out_ready=1. Check the exact two-cycle latency,
    // then check the counters after the output transfer. Starts and ends just after a negedge.
    task automatic send_one(input logic [23:0] d, input int exp_w, input int exp_s,
                            input int exp_o, input string tag);
        out_ready = 1'b1;
        in_data   = d;
        in_valid  = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready_w, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid_lat1"}, out_valid_w, 0);
        @(negedge clk);
        check({tag, "_valid_lat2"}, out_valid_w, 1);
        check({tag, "_valid_sat"},  out_valid_s, 1);
        check({tag, "_sum_wrap"},   sum_w, exp_w);
        check({tag, "_sum_sat"},    sum_sat, exp_s);
        check({tag, "_ovf_wrap"},   ovf_w, exp_o);
        check({tag, "_ovf_sat"},    ovf_sat, exp_o);
        note_delivery(exp_o);
        @(negedge clk);
        check({tag, "_valid_done"}, out_valid_w, 0);
        check({tag, "_cnt8"},       cnt_w, exp_cnt8);
        check({tag, "_cnt8_sat"},   cnt_sat, exp_cnt8);
        check({tag, "_cnt2"},       cnt_c, exp_cnt2);
    endtask

    logic [23:0] bp_vec [6];
    int          bp_w   [6];
    int          bp_s   [6];
    int          bp_o   [6];

    initial begin
        logic [31:0] pattern;
        int          wr;
        int          rd;
        int          cyc;
        logic        stalled_prev;
        logic [5:0]  held_sum;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_data   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready",  in_ready_w, 0);
        check("rst_out_valid", out_valid_w, 0);
        check("rst_sum",       sum_w, 0);
        check("rst_cnt8",      cnt_w, 0);
        check("rst_cnt2",      cnt_c, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready_w, 1);

        // Basic add, wrap/saturate of the all-max vector, and the exact-max boundary.
        send_one(pack(6'd1, 6'd2, 6'd3, 6'd4), 10, 10, 0, "basic");
        send_one(pack(6'd63, 6'd63, 6'd63, 6'd63), 60, 63, 1, "wrap");
        send_one(pack(6'd10, 6'd20, 6'd30, 6'd3), 63, 63, 0, "max_edge");

        // Backpressure stream. The expected sums below were computed by hand.
        bp_vec[0] = pack(6'd1,  6'd1,  6'd1,  6'd1);  bp_w[0] = 4;  bp_s[0] = 4;  bp_o[0] = 0;
        bp_vec[1] = pack(6'd10, 6'd10, 6'd10, 6'd10); bp_w[1] = 40; bp_s[1] = 40; bp_o[1] = 0;
        bp_vec[2] = pack(6'd63, 6'd1,  6'd0,  6'd0);  bp_w[2] = 0;  bp_s[2] = 63; bp_o[2] = 1;
        bp_vec[3] = pack(6'd7,  6'd8,  6'd9,  6'd10); bp_w[3] = 34; bp_s[3] = 34; bp_o[3] = 0;
        bp_vec[4] = pack(6'd0,  6'd0,  6'd0,  6'd0);  bp_w[4] = 0;  bp_s[4] = 0;  bp_o[4] = 0;
        bp_vec[5] = pack(6'd20, 6'd20, 6'd20, 6'd5);  bp_w[5] = 1;  bp_s[5] = 63; bp_o[5] = 1;

        pattern      = 32'hB35A_69C6;
        wr           = 0;
        rd           = 0;
        cyc          = 0;
        stalled_prev = 1'b0;
        held_sum     = '0;
        while (rd < 6 && cyc < 200) begin
            @(negedge clk);
            if (stalled_prev) check("bp_hold_sum", sum_w, held_sum);
            out_ready = pattern[cyc % 32];
            if (wr < 6) begin
                in_valid = 1'b1;
                in_data  = bp_vec[wr];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid_w && !out_ready && (wr - rd) == 2) begin
                check("bp_full_ready", in_ready_w, 0);
            end
            if (out_valid_w && out_ready) begin
                check($sformatf("bp_sum_wrap_%0d", rd), sum_w, bp_w[rd]);
                check($sformatf("bp_sum_sat_%0d", rd),  sum_sat, bp_s[rd]);
                check($sformatf("bp_ovf_%0d", rd),      ovf_w, bp_o[rd]);
                note_delivery(bp_o[rd]);
                rd++;
            end
            if (in_valid && in_ready_w) wr++;
            stalled_prev = out_valid_w && !out_ready;
            held_sum     = sum_w;
            cyc++;
        end
        check("bp_delivered", rd, 6);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", out_valid_w, 0);
        check("bp_cnt8",    cnt_w, exp_cnt8);
        check("bp_cnt2",    cnt_c, exp_cnt2);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pack(6'd63, 6'd63, 6'd63, 6'd63);
        @(negedge clk);
        in_data = pack(6'd1, 6'd1, 6'd1, 6'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_out_valid", out_valid_w, 1);
        check("full_in_ready",  in_ready_w, 0);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_mid_ready_comb", in_ready_w, 0);
        @(negedge clk);
        check("rst_mid_out_valid", out_valid_w, 0);
        check("rst_mid_cnt8",      cnt_w, 0);
        check("rst_mid_cnt2",      cnt_c, 0);
        check("rst_mid_in_ready",  in_ready_w, 0);
        rst      = 1'b0;
        exp_cnt8 = 0;
        exp_cnt2 = 0;
        #1;
        send_one(pack(6'd5, 6'd5, 6'd5, 6'd5), 20, 20, 0, "post_rst");

        // Counter saturation. The 2-bit counter should read 1,2,3,3,3.
        for (int i = 0; i < 5; i++) begin
            send_one(pack(6'd63, 6'd63, 6'd63, 6'd63), 60, 63, 1, $sformatf("cnt_sat_%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
